// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and sizing helpers for the FIFO burst reader.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
//
// Contents:
//   state_t          - burst FSM encoding (IDLE, BURST)
//   burst_cnt_width  - width of the beats_left / pops_left counters
package fifo_burst_reader_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // The counters hold at most one full burst. A burst can never be longer
  // than the FIFO depth, so the smaller of the two bounds the count.
  function automatic int burst_cnt_width(input int burst_len, input int words_amount);
    int max_beats;
    max_beats = (burst_len < words_amount) ? burst_len : words_amount;
    if (max_beats < 1) begin
      max_beats = 1;
    end
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/fifo_burst_reader_skid_buffer.sv
// Two-entry valid/ready register slice between the FIFO pop and the stream.
// Latency: 1 cycle from an accepted input to out_valid.
// Backpressure: in_ready comes from registered occupancy only (never from out_ready).
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake, in_data [WIDTH-1:0]
//   out_valid/out_ready   downstream handshake, out_data [WIDTH-1:0]
module skid_buffer
  import fifo_burst_reader_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // head_q is what the consumer sees; tail_q only fills when the consumer
  // stalls while a word is already being accepted.
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;
  logic             push;
  logic             pop;

  // A single occupied entry still leaves a free slot, so a continuous stream
  // runs at one word per cycle with count_q parked at 1.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            head_q  <= in_data;
            count_q <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= in_data;
          end else if (push) begin
            tail_q  <= in_data;
            count_q <= 2'd2;
          end else if (pop) begin
            count_q <= 2'd0;
          end
        end
        default: begin
          // Full: no push is possible, only drain into head.
          if (pop) begin
            head_q  <= tail_q;
            count_q <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO in BURST_LEN-word bursts onto a valid/ready stream, marking the last word.
// Latency: 1 cycle from FIFO word (popped) to m_valid_o; 1 word/cycle sustained with m_ready_i=1.
// Backpressure: m_ready_i low fills a 2-entry skid stage, then pops stop; fifo_rd_o never depends on m_ready_i.
//
// Build option FIFO_BURST_READER_FLUSH_EN: when defined, a partial burst that has waited
// TIMEOUT idle cycles is emitted as a short burst and flush_o pulses; when undefined a
// partial remainder waits indefinitely, flush_o is 0 and TIMEOUT has no effect.
//
// Ports:
//   clk_i, rst_n_i                                   FIFO read clock, async active-low reset
//   fifo_data_i, fifo_empty_i, fifo_used_words_i     FIFO show-ahead read side
//   fifo_rd_o                                        FIFO pop strobe
//   m_data_o, m_valid_o, m_ready_i, m_last_o         output stream
//   flush_o                                          pulse at the start of a timeout burst
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int WORDS_AMOUNT = 8,
  parameter int ADDR_WIDTH   = $clog2(WORDS_AMOUNT),
  parameter int BURST_LEN    = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  input  logic [ADDR_WIDTH:0]   fifo_used_words_i,
  output logic                  fifo_rd_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic                  flush_o
);

  localparam int CW  = burst_cnt_width(BURST_LEN, WORDS_AMOUNT);
  localparam int AVW = ADDR_WIDTH + 2;

  localparam logic [AVW-1:0] BURST_LEN_AV = AVW'(BURST_LEN);
  localparam logic [CW-1:0]  BURST_LEN_CW = CW'(BURST_LEN);
  localparam logic [CW-1:0]  CNT_ONE      = CW'(1);

  // Out-of-range configurations elaborate this empty marker block so they
  // are easy to spot in the elaborated hierarchy.
  if (BURST_LEN < 1 || BURST_LEN > WORDS_AMOUNT || TIMEOUT < 1) begin : g_bad_params
  end

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   beats_left_q;
  logic [CW-1:0]   beats_left_d;
  logic [CW-1:0]   pops_left_q;
  logic [CW-1:0]   pops_left_d;

  logic [AVW-1:0]  avail;
  logic            avail_zero;
  logic            avail_full;
  logic            timeout_hit;

  logic            pop;
  logic            xfer;
  logic            skid_in_ready;
  logic            skid_out_valid;
  logic [DATA_WIDTH:0] skid_in_data;
  logic [DATA_WIDTH:0] skid_out_data;

  // used_words excludes the word already presented at the FIFO output, so
  // !empty adds that one back. The extra MSB keeps a full FIFO from wrapping.
  assign avail      = {1'b0, fifo_used_words_i} + {{(AVW-1){1'b0}}, ~fifo_empty_i};
  assign avail_zero = (avail == '0);
  assign avail_full = (avail >= BURST_LEN_AV);

  // Pops are gated on registered skid occupancy only. The empty check lets a
  // burst pause and resume if the FIFO ever runs dry mid-burst.
  assign pop  = (state_q == BURST) && !fifo_empty_i && (pops_left_q != '0) && skid_in_ready;
  assign xfer = skid_out_valid && m_ready_i;

  // The last flag travels with its data word through the skid stage.
  assign skid_in_data = {(pops_left_q == CNT_ONE), fifo_data_i};

  skid_buffer #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .in_valid  (pop),
    .in_ready  (skid_in_ready),
    .in_data   (skid_in_data),
    .out_valid (skid_out_valid),
    .out_ready (m_ready_i),
    .out_data  (skid_out_data)
  );

  assign fifo_rd_o = pop;
  assign m_valid_o = skid_out_valid;
  assign m_data_o  = skid_out_data[DATA_WIDTH-1:0];
  // Gate with valid so a drained slice never shows a stale last flag.
  assign m_last_o  = skid_out_valid && skid_out_data[DATA_WIDTH];

`ifdef FIFO_BURST_READER_FLUSH_EN
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

  logic [IW-1:0] idle_cnt_q;
  logic          flush_q;

  // Only a partial burst (some data, less than BURST_LEN) ages.
  assign timeout_hit = (state_q == IDLE) && !avail_zero && !avail_full &&
                       (idle_cnt_q == IDLE_MAX);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idle_cnt_q <= '0;
    end else if ((state_q != IDLE) || avail_zero || avail_full || timeout_hit) begin
      idle_cnt_q <= '0;
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end

  // Registered, so the pulse lines up with the first BURST cycle of the
  // short burst.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      flush_q <= 1'b0;
    end else begin
      flush_q <= timeout_hit;
    end
  end

  assign flush_o = flush_q;
`else
  assign timeout_hit = 1'b0;
  assign flush_o     = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      pops_left_q  <= '0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      pops_left_q  <= pops_left_d;
    end
  end

  // beats_left counts stream transfers still owed; pops_left counts FIFO
  // reads still owed. They start equal and pops_left runs ahead by up to
  // the skid depth.
  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    pops_left_d  = pops_left_q;
    case (state_q)
      IDLE: begin
        if (avail_full) begin
          state_d      = BURST;
          beats_left_d = BURST_LEN_CW;
          pops_left_d  = BURST_LEN_CW;
        end else if (timeout_hit) begin
          // avail < BURST_LEN here, so the truncation is lossless.
          state_d      = BURST;
          beats_left_d = CW'(avail);
          pops_left_d  = CW'(avail);
        end
      end
      BURST: begin
        if (pop) begin
          pops_left_d = pops_left_q - 1'b1;
        end
        if (xfer) begin
          beats_left_d = beats_left_q - 1'b1;
          // The beat carrying the last flag is the one leaving with
          // beats_left at 1; the next IDLE cycle re-evaluates avail.
          if (beats_left_q == CNT_ONE) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
